ahb_master_arbiter: RTL and testbench

Two-port AHB-Lite master front end. It shares the single CPU AHB master port between the instruction-fetch requester (port 0) and the load/store requester (port 1). It accepts one request at a time through a req/ack handshake and sequences the AHB address and data phases from registered copies of that request. It returns a one-cycle done pulse carrying read data and error status to the owning port, and it sits between the fetch/LSU controllers and the AHB interconnect.

---
 rtl/ahb_master_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
//
// Two-port AHB-Lite master front end. Port 0 (instruction fetch) and port 1
// (load/store) share one CPU AHB master port. One request is accepted at a
// time via a req/ack handshake, registered, and then sequenced through the
// AHB address and data phases. A one-cycle done pulse returns read data and
// error status to the port that owned the transfer.
//
// Build option:
//   AHB_ARB_RR_EN  defined   -> round-robin between the two ports on
//                               simultaneous requests (last-owner flag)
//                  undefined -> fixed priority, port 1 beats port 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req/write/addr/wdata/size{0,1}
//                            request inputs per port (size 11 acts as word)
//   ack0/ack1                one-cycle pulse, request has been latched
//   done0/done1              one-cycle pulse, transfer complete
//   rdata, err               result, valid while a done pulse is high,
//                            held between done pulses
//   CPU_H*                   AHB-Lite master signals
// ---------------------------------------------------------------------------
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no transfer outstanding; arbitrate and ack a pending request
// ADDR  | address phase (HTRANS = NONSEQ), held until HREADY
// DATA  | data phase; wait states while HREADY low
// ERR   | second cycle of a two-cycle ERROR response, waiting for HREADY
// DONE  | done pulse to the owner; arbitrate again for back-to-back issue
// ---------------------------------------------------------------------------
module ahb_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              write0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [1:0]        size0,

    input  logic              req1,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        size1,

    output logic              ack0,
    output logic              ack1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,

    output logic [ADDR_W-1:0] CPU_HADDR,
    output logic              CPU_HWRITE,
    output logic [2:0]        CPU_HSIZE,
    output logic [2:0]        CPU_HBURST,
    output logic [1:0]        CPU_HTRANS,
    output logic              CPU_HMASTLOCK,
    output logic [DATA_W-1:0] CPU_HWDATA,
    input  logic [DATA_W-1:0] CPU_HRDATA,
    input  logic              CPU_HREADY,
    input  logic [1:0]        CPU_HRESP
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    state_t state, state_nxt;

    // registered copy of the accepted request
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_size;
    logic              r_owner;

    logic              grant;
    logic              win1;
    logic              resp_err;

`ifdef AHB_ARB_RR_EN
    // 1 = port 1 was granted most recently
    logic              last_owner;
`endif

    assign resp_err = (CPU_HRESP == HRESP_ERROR);

    // ------------------------------------------------------------------
    // Arbitration. Only IDLE and DONE may accept a request. Acks are
    // suppressed while rst is high, since the request would not be latched.
    // ------------------------------------------------------------------
    always_comb begin
        win1  = 1'b0;
        grant = 1'b0;
`ifdef AHB_ARB_RR_EN
        // with both requesting, grant the port that did not win last time
        win1 = req1 & (~req0 | ~last_owner);
`else
        win1 = req1;
`endif
        if (((state == ST_IDLE) || (state == ST_DONE)) && (req0 || req1) && !rst) begin
            grant = 1'b1;
        end
    end

    assign ack0 = grant & ~win1;
    assign ack1 = grant &  win1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (CPU_HREADY) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (CPU_HREADY)    state_nxt = ST_DONE;
                else if (resp_err) state_nxt = ST_ERR;
            end
            ST_ERR: begin
                if (CPU_HREADY) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = grant ? ST_ADDR : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Request capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= 2'b00;
            r_owner <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            if (grant) begin
                r_owner <= win1;
                if (win1) begin
                    r_write <= write1;
                    r_addr  <= addr1;
                    r_wdata <= wdata1;
                    r_size  <= (size1 == 2'b11) ? 2'b10 : size1;
                end else begin
                    r_write <= write0;
                    r_addr  <= addr0;
                    r_wdata <= wdata0;
                    r_size  <= (size0 == 2'b11) ? 2'b10 : size0;
                end
            end

            // A single-cycle ERROR (HREADY high with ERROR) is tolerated and
            // completes with err set; rdata keeps its previous value on errors.
            if ((state == ST_DATA) && CPU_HREADY) begin
                err <= resp_err;
                if (!resp_err) rdata <= r_write ? '0 : CPU_HRDATA;
            end else if ((state == ST_ERR) && CPU_HREADY) begin
                err <= 1'b1;
            end
        end
    end

`ifdef AHB_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst)        last_owner <= 1'b1;
        else if (grant) last_owner <= win1;
    end
`endif

    // ------------------------------------------------------------------
    // AHB outputs. Address/control come straight from the request
    // registers, so they stay stable through address-phase wait states.
    // ------------------------------------------------------------------
    assign CPU_HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign CPU_HADDR     = r_addr;
    assign CPU_HWRITE    = r_write;
    assign CPU_HSIZE     = (state == ST_IDLE) ? 3'b010 : {1'b0, r_size};
    assign CPU_HBURST    = 3'b000;
    assign CPU_HMASTLOCK = 1'b0;
    assign CPU_HWDATA    = (((state == ST_DATA) || (state == ST_ERR)) && r_write) ? r_wdata : '0;

    assign done0 = (state == ST_DONE) & ~r_owner;
    assign done1 = (state == ST_DONE) &  r_owner;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
module tb_ahb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, write0, write1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    size0, size1;
    logic          ack0, ack1, done0, done1, err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] CPU_HADDR;
    logic          CPU_HWRITE, CPU_HMASTLOCK, CPU_HREADY;
    logic [2:0]    CPU_HSIZE, CPU_HBURST;
    logic [1:0]    CPU_HTRANS, CPU_HRESP;
    logic [DW-1:0] CPU_HWDATA, CPU_HRDATA;

    ahb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0), .size0(size0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1), .size1(size1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err),
        .CPU_HADDR(CPU_HADDR), .CPU_HWRITE(CPU_HWRITE), .CPU_HSIZE(CPU_HSIZE),
        .CPU_HBURST(CPU_HBURST), .CPU_HTRANS(CPU_HTRANS), .CPU_HMASTLOCK(CPU_HMASTLOCK),
        .CPU_HWDATA(CPU_HWDATA), .CPU_HRDATA(CPU_HRDATA),
        .CPU_HREADY(CPU_HREADY), .CPU_HRESP(CPU_HRESP)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // pending requests per port
    logic          p_v [2];
    logic          p_w [2];
    logic [AW-1:0] p_a [2];
    logic [DW-1:0] p_d [2];
    logic [1:0]    p_s [2];

    // transaction-level reference model
    int            cyc, t_ack, ds, dcyc, wa, wd, em, dlen, k, win, last, n_xfer;
    logic          busy, grant, rst_now, prev_rst, in_addr, in_data, is_done, is_free;
    logic          own, tw, m_err, known;
    logic [AW-1:0] taddr;
    logic [DW-1:0] twdata, m_rdata, hrd;
    logic [1:0]    tsize;
    logic [2:0]    exp_sz;

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; write0 = 0; write1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; size0 = 0; size1 = 0;
        CPU_HRDATA = '0; CPU_HREADY = 1'b1; CPU_HRESP = 2'b00;
        for (int p = 0; p < 2; p++) begin
            p_v[p] = 0; p_w[p] = 0; p_a[p] = '0; p_d[p] = '0; p_s[p] = 0;
        end
        busy = 0; cyc = 0; t_ack = 0; ds = 0; dcyc = 0; wa = 0; wd = 0; em = 0; dlen = 0;
        last = 1; n_xfer = 0; own = 0; tw = 0; taddr = '0; twdata = '0; tsize = 0;
        m_err = 0; m_rdata = '0; known = 1; prev_rst = 1;

        repeat (2) @(posedge clk);
        req0 = 1; req1 = 1;   // requests during reset must not be acked
        @(negedge clk);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_htrans", CPU_HTRANS, 0);
        chk("rst_hsize", CPU_HSIZE, 3'b010);
        chk("rst_haddr", CPU_HADDR, 0);
        chk("rst_hwrite", CPU_HWRITE, 0);
        chk("rst_hwdata", CPU_HWDATA, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (p_v[p]) begin
                    if ($urandom_range(0, 24) == 0) p_v[p] = 0;   // unacked drop
                end else if ($urandom_range(0, 2) == 0) begin
                    p_v[p] = 1;
                    p_w[p] = 1'($urandom_range(0, 1));
                    p_a[p] = $urandom;
                    p_d[p] = $urandom;
                    p_s[p] = 2'($urandom_range(0, 3));
                end
            end

            in_addr = busy && (cyc >= t_ack + 1) && (cyc <= t_ack + 1 + wa);
            in_data = busy && (cyc >= ds) && (cyc < dcyc);
            is_done = busy && (cyc == dcyc);
            is_free = !busy || is_done;
            k       = cyc - ds;
            rst_now = in_data && (k < wd) && ($urandom_range(0, 19) == 0);

            hrd = $urandom;
            if (in_addr) begin
                CPU_HREADY = (cyc == t_ack + 1 + wa);
                CPU_HRESP  = 2'b00;
            end else if (in_data) begin
                case (em)
                    0: begin CPU_HREADY = (k == wd);     CPU_HRESP = 2'b00; end
                    1: begin CPU_HREADY = (k == wd + 1); CPU_HRESP = (k >= wd) ? 2'b01 : 2'b00; end
                    default: begin CPU_HREADY = (k == wd); CPU_HRESP = (k == wd) ? 2'b01 : 2'b00; end
                endcase
            end else begin
                CPU_HREADY = 1'($urandom_range(0, 1));
                CPU_HRESP  = 2'b00;
            end

            grant = 0; win = 0;
            if (!rst_now && is_free && (p_v[0] || p_v[1])) begin
                grant = 1;
`ifdef AHB_ARB_RR_EN
                if (p_v[0] && p_v[1]) win = (last == 1) ? 0 : 1;
                else                  win = p_v[1] ? 1 : 0;
`else
                win = p_v[1] ? 1 : 0;
`endif
            end

            rst = rst_now;
            CPU_HRDATA = hrd;
            req0 = p_v[0]; write0 = p_w[0]; addr0 = p_a[0]; wdata0 = p_d[0]; size0 = p_s[0];
            req1 = p_v[1]; write1 = p_w[1]; addr1 = p_a[1]; wdata1 = p_d[1]; size1 = p_s[1];

            @(negedge clk);
            chk("ack0", ack0, grant && win == 0);
            chk("ack1", ack1, grant && win == 1);
            chk("done0", done0, is_done && !own);
            chk("done1", done1, is_done && own);
            chk("htrans", CPU_HTRANS, in_addr ? 2'b10 : 2'b00);
            chk("err", err, m_err);
            if (known) chk("rdata", rdata, m_rdata);
            if (in_addr) begin
                exp_sz = (tsize == 2'b11) ? 3'b010 : {1'b0, tsize};
                chk("haddr", CPU_HADDR, taddr);
                chk("hwrite", CPU_HWRITE, tw);
                chk("hsize", CPU_HSIZE, exp_sz);
            end
            if (in_data) chk("hwdata", CPU_HWDATA, tw ? twdata : '0);
            if (!busy) chk("hsize_idle", CPU_HSIZE, 3'b010);
            if (prev_rst) begin
                chk("post_rst_haddr", CPU_HADDR, 0);
                chk("post_rst_hwdata", CPU_HWDATA, 0);
            end
            if (n % 64 == 0) begin
                chk("hburst", CPU_HBURST, 0);
                chk("hmastlock", CPU_HMASTLOCK, 0);
            end

            prev_rst = rst_now;
            if (rst_now) begin
                busy = 0; m_err = 0; m_rdata = '0; known = 1; last = 1;
            end else begin
                if (in_data && k == dlen - 1) begin
                    if (em == 0) begin
                        m_err = 0; m_rdata = tw ? '0 : hrd; known = 1;
                    end else begin
                        m_err = 1; known = 0;
                    end
                end
                if (is_done) busy = 0;
                if (grant) begin
                    busy = 1; t_ack = cyc; own = (win == 1); last = win;
                    tw = p_w[win]; taddr = p_a[win]; twdata = p_d[win]; tsize = p_s[win];
                    p_v[win] = 0;
                    wa = $urandom_range(0, 3);
                    wd = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                    case ($urandom_range(0, 9))
                        0:       em = 1;
                        1:       em = 2;
                        default: em = 0;
                    endcase
                    dlen = (em == 1) ? wd + 2 : wd + 1;
                    ds   = cyc + 2 + wa;
                    dcyc = ds + dlen;
                    n_xfer++;
                end
            end
            cyc++;
        end

        chk("xfer_activity", n_xfer > 100, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
